// File: rtl/uart_io_pkg.sv
// rtl/uart_io_pkg.sv - shared types for the UART I/O sequencer
package uart_io_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        IN_IDLE,
        IN_DONE
    } in_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_HOLD,
        TX_WAIT
    } tx_state_t;

    localparam int RX_DEPTH_LOG2_DEFAULT = 9;
    localparam int TX_DEPTH_LOG2_DEFAULT = 4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers
// Ports: clk, rst (async, active-high); push/push_data write when not full;
//        pop advances when not empty; head is the current front entry;
//        full, empty and count (occupancy, DEPTH_LOG2+1 bits).
module sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    logic [WIDTH-1:0]    mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    // Pointers carry one extra wrap bit: equal index with differing wrap bit means full.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // Full is judged on the pre-pop state, so a push into a full FIFO is dropped
    // even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_io_ctrl.sv
// rtl/uart_io_ctrl.sv - buffers UART RX bytes for the core and paces core output into uart_tx
// Ports: clk, rst (async, active-high)
//        CPU in side : in_req -> in_data/in_valid (one-cycle pulse)
//        CPU out side: out_req/out_data, out_ready (TX FIFO has room)
//        uart_rx     : rx_data, rx_ready, ferr
//        uart_tx     : tx_data, tx_start (one-cycle pulse), tx_busy
//        status      : status_clr, sticky rx_overflow/rx_ferr, rx_count occupancy
module uart_io_ctrl
    import uart_io_pkg::*;
#(
    parameter int RX_DEPTH_LOG2 = 9,
    parameter int TX_DEPTH_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_req,
    output logic [7:0]               in_data,
    output logic                     in_valid,
    input  logic                     out_req,
    input  logic [7:0]               out_data,
    output logic                     out_ready,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ready,
    input  logic                     ferr,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    input  logic                     status_clr,
    output logic                     rx_overflow,
    output logic                     rx_ferr,
    output logic [RX_DEPTH_LOG2:0]   rx_count
);

    byte_t                   rx_head;
    byte_t                   tx_head;
    logic                    rx_full;
    logic                    rx_empty;
    logic                    tx_full;
    logic                    tx_empty;
    logic [TX_DEPTH_LOG2:0]  unused_tx_count;
    logic                    rx_pop;
    logic                    tx_pop;
    logic                    ferr_set;
    logic                    ovf_set;
    in_state_t               in_state;
    tx_state_t               tx_state;

    assign ferr_set  = rx_ready && ferr;
    assign ovf_set   = rx_ready && !ferr && rx_full;
    assign rx_pop    = (in_state == IN_IDLE) && in_req && !rx_empty;
    assign tx_pop    = (tx_state == TX_IDLE) && !tx_empty && !tx_busy;
    // Held low while reset is asserted so every output reads 0 during reset.
    assign out_ready = !tx_full && !rst;

    sync_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2), .WIDTH(8)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_ready && !ferr),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    sync_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2), .WIDTH(8)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (out_req && out_ready),
        .push_data (out_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (unused_tx_count)
    );

    // IN side: pop on request, present the byte for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state <= IN_IDLE;
            in_data  <= '0;
            in_valid <= 1'b0;
        end else begin
            case (in_state)
                IN_IDLE: begin
                    in_valid <= 1'b0;
                    if (rx_pop) begin
                        in_data  <= rx_head;
                        in_valid <= 1'b1;
                        in_state <= IN_DONE;
                    end
                end
                IN_DONE: begin
                    in_valid <= 1'b0;
                    in_state <= IN_IDLE;
                end
                default: begin
                    in_valid <= 1'b0;
                    in_state <= IN_IDLE;
                end
            endcase
        end
    end

    // TX side: one byte per uart_tx frame. TX_HOLD gives uart_tx a cycle to
    // raise busy before TX_WAIT starts watching it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_data  <= '0;
            tx_start <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_start <= 1'b0;
                    if (tx_pop) begin
                        tx_data  <= tx_head;
                        tx_start <= 1'b1;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    tx_start <= 1'b0;
                    tx_state <= TX_HOLD;
                end
                TX_HOLD: begin
                    tx_start <= 1'b0;
                    tx_state <= TX_WAIT;
                end
                TX_WAIT: begin
                    tx_start <= 1'b0;
                    if (!tx_busy) tx_state <= TX_IDLE;
                end
                default: begin
                    tx_start <= 1'b0;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // Sticky flags: a new error in the same cycle wins over status_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_overflow <= 1'b0;
            rx_ferr     <= 1'b0;
        end else begin
            if (ovf_set)         rx_overflow <= 1'b1;
            else if (status_clr) rx_overflow <= 1'b0;
            if (ferr_set)        rx_ferr <= 1'b1;
            else if (status_clr) rx_ferr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// tb/tb_uart_io_ctrl.sv - self-checking bench for uart_io_ctrl
module tb_uart_io_ctrl;

    logic       clk;
    logic       rst;
    logic       in_req;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_req;
    logic [7:0] out_data;
    logic       out_ready;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       ferr;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       status_clr;
    logic       rx_overflow;
    logic       rx_ferr;
    logic [9:0] rx_count;

    uart_io_ctrl #(.RX_DEPTH_LOG2(9), .TX_DEPTH_LOG2(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_req      (in_req),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_req     (out_req),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .ferr        (ferr),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .status_clr  (status_clr),
        .rx_overflow (rx_overflow),
        .rx_ferr     (rx_ferr),
        .rx_count    (rx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- uart_tx model: busy for busy_len cycles after each start
    int   busy_len  = 4;
    int   busy_cnt  = 0;
    logic start_seen = 1'b0;
    logic hold_busy  = 1'b0;

    always @(posedge clk) begin
        #1;
        if (start_seen) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
        tx_busy    = hold_busy || (busy_cnt > 0);
        start_seen = tx_start;
    end

    // ---------------- reference model / scoreboard, evaluated mid-cycle
    logic [7:0] m_rx[$];
    logic [7:0] m_tx[$];
    logic       m_ovf = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_exp_valid = 1'b0;
    logic [7:0] m_exp_byte = 8'h00;
    logic       m_prev_busy = 1'b0;
    int         n_starts = 0;

    always @(negedge clk) begin
        int   pre_sz;
        logic in_done;
        if (rst) begin
            chk("rst_in_valid", in_valid, 0);
            chk("rst_in_data", in_data, 0);
            chk("rst_tx_start", tx_start, 0);
            chk("rst_tx_data", tx_data, 0);
            chk("rst_out_ready", out_ready, 0);
            chk("rst_rx_overflow", rx_overflow, 0);
            chk("rst_rx_ferr", rx_ferr, 0);
            chk("rst_rx_count", rx_count, 0);
            m_rx.delete();
            m_tx.delete();
            m_ovf = 1'b0;
            m_ferr = 1'b0;
            m_exp_valid = 1'b0;
        end else begin
            // CPU in side
            if (m_exp_valid) begin
                chk("in_valid_pulse", in_valid, 1);
                chk("in_data", in_data, m_exp_byte);
            end else begin
                chk("in_valid_idle", in_valid, 0);
            end
            in_done = m_exp_valid;
            m_exp_valid = 1'b0;
            chk("rx_count", rx_count, m_rx.size());
            chk("rx_overflow", rx_overflow, m_ovf);
            chk("rx_ferr", rx_ferr, m_ferr);

            // uart_tx side
            if (tx_start) begin
                n_starts++;
                chk("tx_start_while_busy", m_prev_busy, 0);
                chk("tx_start_with_data", m_tx.size() != 0, 1);
                if (m_tx.size() != 0) chk("tx_data_order", tx_data, m_tx.pop_front());
            end
            chk("out_ready", out_ready, m_tx.size() < 16);

            // effects of the inputs at the coming edge
            pre_sz = m_rx.size();
            if (in_req && !in_done && pre_sz > 0) begin
                m_exp_byte  = m_rx.pop_front();
                m_exp_valid = 1'b1;
            end
            if (rx_ready && !ferr && pre_sz < 512) m_rx.push_back(rx_data);
            if (rx_ready && ferr) m_ferr = 1'b1;
            else if (status_clr) m_ferr = 1'b0;
            if (rx_ready && !ferr && pre_sz >= 512) m_ovf = 1'b1;
            else if (status_clr) m_ovf = 1'b0;
            if (out_req && m_tx.size() < 16) m_tx.push_back(out_data);
        end
        m_prev_busy = tx_busy;
    end

    // ---------------- driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic f);
        rx_data  = b;
        ferr     = f;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        ferr     = 1'b0;
    endtask

    task automatic pop_one(output logic [7:0] got);
        bit ok;
        ok = 1'b0;
        got = 8'h00;
        in_req = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (in_valid) begin
                got = in_data;
                ok = 1'b1;
                break;
            end
        end
        in_req = 1'b0;
        chk("in_handshake_done", ok, 1);
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        out_data = b;
        out_req  = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (out_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        out_req = 1'b0;
        chk("out_accept", ok, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       f;
        int         exp_count;
        logic       exp_ferr;
    } rx_vec_t;

    typedef struct {
        logic [7:0] exp_data;
        int         exp_count;
    } pop_vec_t;

    rx_vec_t  rx_tbl[4];
    pop_vec_t pop_tbl[3];

    initial begin
        logic [7:0] got;
        int         s0;
        bit         seen;

        rx_tbl[0] = '{8'h41, 1'b0, 1, 1'b0};
        rx_tbl[1] = '{8'h42, 1'b0, 2, 1'b0};
        rx_tbl[2] = '{8'h43, 1'b0, 3, 1'b0};
        rx_tbl[3] = '{8'hFF, 1'b1, 3, 1'b1};
        pop_tbl[0] = '{8'h41, 2};
        pop_tbl[1] = '{8'h42, 1};
        pop_tbl[2] = '{8'h43, 0};

        rst = 1'b1; in_req = 0; out_req = 0; out_data = 0;
        rx_data = 0; rx_ready = 0; ferr = 0; status_clr = 0;
        tx_busy = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("post_reset_out_ready", out_ready, 1);
        chk("post_reset_rx_count", rx_count, 0);

        // RX pushes including a framing error, then in_req handshakes
        foreach (rx_tbl[i]) begin
            rx_byte(rx_tbl[i].data, rx_tbl[i].f);
            chk("tbl_rx_count", rx_count, rx_tbl[i].exp_count);
            chk("tbl_rx_ferr", rx_ferr, rx_tbl[i].exp_ferr);
        end
        foreach (pop_tbl[i]) begin
            in_req = 1'b1;
            tick();
            chk("tbl_in_latency", in_valid, 1);
            chk("tbl_in_data", in_data, pop_tbl[i].exp_data);
            in_req = 1'b0;
            tick();
            chk("tbl_in_valid_single", in_valid, 0);
            chk("tbl_pop_count", rx_count, pop_tbl[i].exp_count);
        end

        // in_req on an empty FIFO while the byte arrives in the same cycle
        in_req = 1'b1; rx_data = 8'h5A; rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("same_cycle_no_early_valid", in_valid, 0);
        tick();
        chk("same_cycle_valid", in_valid, 1);
        chk("same_cycle_data", in_data, 8'h5A);
        in_req = 1'b0;
        tick();
        chk("same_cycle_single_pop", in_valid, 0);
        chk("same_cycle_count", rx_count, 0);

        // set beats clear
        status_clr = 1'b1;
        rx_byte(8'h00, 1'b1);
        status_clr = 1'b0;
        chk("ferr_set_beats_clr", rx_ferr, 1);
        status_clr = 1'b1; tick(); status_clr = 1'b0;
        chk("ferr_cleared", rx_ferr, 0);

        // overflow: 513 bytes, last one lost
        for (int i = 0; i < 513; i++) rx_byte(i[7:0], 1'b0);
        chk("ovf_count", rx_count, 512);
        chk("ovf_flag", rx_overflow, 1);
        status_clr = 1'b1; tick(); status_clr = 1'b0;
        chk("ovf_cleared", rx_overflow, 0);
        for (int i = 0; i < 512; i++) pop_one(got);
        chk("ovf_last_byte", got, 8'hFF);
        chk("ovf_drained", rx_count, 0);

        // TX while uart_tx busy
        busy_len = 5;
        hold_busy = 1'b1;
        s0 = n_starts;
        send_byte(8'hAA);
        send_byte(8'h55);
        for (int i = 0; i < 200; i++) tick();
        chk("tx_no_start_while_busy", n_starts - s0, 0);
        hold_busy = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("tx_two_starts", n_starts - s0, 2);

        // fill TX, then reset mid-frame
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'h10 + i[7:0]);
        chk("tx_full_not_ready", out_ready, 0);
        out_data = 8'hEE; out_req = 1'b1;
        tick(); tick();
        out_req = 1'b0;
        busy_len = 30;
        hold_busy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        chk("tx_fill_started", seen, 1);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_start", tx_start, 0);
        chk("mid_rst_out_ready", out_ready, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        tick();
        rst = 1'b0;
        s0 = n_starts;
        for (int i = 0; i < 60; i++) tick();
        chk("no_start_after_rst", n_starts - s0, 0);
        chk("rx_empty_after_rst", rx_count, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (in_valid) in_req = 1'b0;
            else if (!in_req && $urandom_range(0, 2) == 0) in_req = 1'b1;
            rx_ready   = ($urandom_range(0, 3) == 0);
            rx_data    = 8'($urandom);
            ferr       = ($urandom_range(0, 15) == 0);
            out_req    = ($urandom_range(0, 2) == 0);
            out_data   = 8'($urandom);
            status_clr = ($urandom_range(0, 31) == 0);
            busy_len   = $urandom_range(1, 6);
        end
        tick();
        rx_ready = 0; ferr = 0; out_req = 0; status_clr = 0; in_req = 0;
        tick(); tick();
        for (int i = 0; i < 600 && rx_count != 0; i++) pop_one(got);
        chk("rand_rx_drained", rx_count, 0);
        for (int i = 0; i < 3000; i++) begin
            if (m_tx.size() == 0 && !tx_busy) break;
            tick();
        end
        tick(); tick();
        chk("rand_tx_drained", m_tx.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
